// File: rtl/multicycle_control_if.sv
// Control-unit bundle: instruction/status inputs from the datapath, control strobes back to it.
// master = datapath side, slave = control unit.
interface multicycle_control_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        Mem_Ack;
   logic [2:0]  State;
   logic        IR_LdEn;
   logic        PC_LdEn;
   logic        PC_Sel;
   logic        RF_WrEn;
   logic        RF_B_Sel;
   logic        RF_WrData_Sel;
   logic        ALU_Bin_Sel;
   logic        ALU_A_Zero;
   logic [3:0]  ALU_Func;
   logic [1:0]  ImmExt_Sel;
   logic        Mem_Req;
   logic        Mem_WrEn;
   logic        ByteOp;
   logic        Illegal;

   modport master (
      output Instr, Zero, Mem_Ack,
      input  State, IR_LdEn, PC_LdEn, PC_Sel, RF_WrEn, RF_B_Sel, RF_WrData_Sel,
             ALU_Bin_Sel, ALU_A_Zero, ALU_Func, ImmExt_Sel, Mem_Req, Mem_WrEn, ByteOp, Illegal
   );

   modport slave (
      input  Instr, Zero, Mem_Ack,
      output State, IR_LdEn, PC_LdEn, PC_Sel, RF_WrEn, RF_B_Sel, RF_WrData_Sel,
             ALU_Bin_Sel, ALU_A_Zero, ALU_Func, ImmExt_Sel, Mem_Req, Mem_WrEn, ByteOp, Illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing plus combinational decode.
// Illegal opcodes are sticky until reset.
module multicycle_control (
   input logic                 Clk,
   input logic                 Reset,
   multicycle_control_if.slave bus
);

   typedef enum logic [2:0] {
      StFetch  = 3'b000,
      StDecode = 3'b001,
      StExec   = 3'b010,
      StMem    = 3'b011,
      StWb     = 3'b100
   } state_e;

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [5:0] opcode;
   logic [3:0] func;
   logic       is_r, is_li, is_lui, is_addi, is_nandi, is_ori;
   logic       is_b, is_beq, is_bne, is_lb, is_lw, is_sb, is_sw;
   logic       is_legal, is_alu, is_load, is_store, is_branch, is_itype, taken;
   logic       unused_instr;

   assign opcode       = bus.Instr[31:26];
   assign func         = bus.Instr[3:0];
   assign unused_instr = ^bus.Instr[25:4];

   assign is_r     = (opcode == 6'b100000);
   assign is_li    = (opcode == 6'b111000);
   assign is_lui   = (opcode == 6'b111001);
   assign is_addi  = (opcode == 6'b110000);
   assign is_nandi = (opcode == 6'b110010);
   assign is_ori   = (opcode == 6'b110011);
   assign is_b     = (opcode == 6'b111111);
   assign is_beq   = (opcode == 6'b000000);
   assign is_bne   = (opcode == 6'b000001);
   assign is_lb    = (opcode == 6'b000011);
   assign is_lw    = (opcode == 6'b000111);
   assign is_sb    = (opcode == 6'b001111);
   assign is_sw    = (opcode == 6'b011111);

   assign is_alu    = is_r | is_li | is_lui | is_addi | is_nandi | is_ori;
   assign is_load   = is_lb | is_lw;
   assign is_store  = is_sb | is_sw;
   assign is_branch = is_b | is_beq | is_bne;
   assign is_legal  = is_alu | is_load | is_store | is_branch;
   assign is_itype  = is_legal & ~is_r;
   assign taken     = is_b | (is_beq & bus.Zero) | (is_bne & ~bus.Zero);

   // Datapath select decode is purely a function of the current instruction word.
   always_comb begin
      bus.ImmExt_Sel = 2'b00;
      if (is_nandi || is_ori)  bus.ImmExt_Sel = 2'b01;
      if (is_lui)              bus.ImmExt_Sel = 2'b10;
      if (is_branch)           bus.ImmExt_Sel = 2'b11;

      bus.ALU_Func = 4'b0000;
      if (is_r)                bus.ALU_Func = func;
      if (is_nandi)            bus.ALU_Func = 4'b0101;
      if (is_ori)              bus.ALU_Func = 4'b0011;
      if (is_beq || is_bne)    bus.ALU_Func = 4'b0001;
   end

   assign bus.ALU_A_Zero  = is_li | is_lui;
   assign bus.ALU_Bin_Sel = is_itype & ~(is_beq | is_bne);
   assign bus.RF_B_Sel    = is_itype;
   assign bus.State       = state_q;
   assign bus.Illegal     = illegal_q;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      illegal_d         = illegal_q;
      bus.IR_LdEn       = 1'b0;
      bus.PC_LdEn       = 1'b0;
      bus.PC_Sel        = 1'b0;
      bus.RF_WrEn       = 1'b0;
      bus.RF_WrData_Sel = 1'b0;
      bus.Mem_Req       = 1'b0;
      bus.Mem_WrEn      = 1'b0;
      bus.ByteOp        = 1'b0;
      // Strobes stay quiet for the whole time reset is held low.
      if (Reset) begin
         unique case (state_q)
            StFetch: begin
               bus.IR_LdEn = 1'b1;
               state_d     = StDecode;
            end
            StDecode: begin
               if (!is_legal) begin
                  illegal_d   = 1'b1;
                  bus.PC_LdEn = 1'b1;
                  state_d     = StFetch;
               end else begin
                  state_d = StExec;
               end
            end
            StExec: begin
               if (is_branch) begin
                  bus.PC_LdEn = 1'b1;
                  bus.PC_Sel  = taken;
                  state_d     = StFetch;
               end else if (is_load || is_store) begin
                  state_d = StMem;
               end else if (is_alu) begin
                  state_d = StWb;
               end else begin
                  state_d = StFetch;
               end
            end
            StMem: begin
               bus.Mem_Req  = 1'b1;
               bus.Mem_WrEn = is_store;
               bus.ByteOp   = is_lb | is_sb;
               if (bus.Mem_Ack) begin
                  if (is_load) begin
                     state_d = StWb;
                  end else begin
                     bus.PC_LdEn = 1'b1;
                     state_d     = StFetch;
                  end
               end
            end
            StWb: begin
               bus.RF_WrEn       = 1'b1;
               bus.RF_WrData_Sel = is_load;
               bus.PC_LdEn       = 1'b1;
               state_d           = StFetch;
            end
            default: state_d = StFetch;
         endcase
      end
   end

endmodule
